spec_adder_vl: RTL

Parametrised variable-latency speculative adder, the next generation of the single-boundary carry-select unit. Splits a WIDTH-bit addition into NSEG = WIDTH/SEG segments, speculates each inter-segment carry from a P-bit window, and flags boundaries where speculation failed. In approximate mode it returns the speculative sum after one cycle. In exact mode it iterates carry correction until the sum is exact. Sits in the adder datapath behind a valid/ready handshake.

---
 rtl/spec_adder_vl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spec_adder_vl.sv
// rtl/spec_adder_vl.sv - variable-latency speculative segmented adder
// Approximate mode returns the speculative sum; exact mode iterates carry repair until consistent.
module spec_adder_vl #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int P     = 2,
  localparam int NSEG = WIDTH / SEG,
  localparam int NW   = $clog2(NSEG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
  output logic [NW-1:0]    ncorr
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              mode_q, mode_d;
  logic [NSEG-1:0]   c_q, c_d;
  logic              err_q, err_d;
  logic [NW-1:0]     ncorr_q, ncorr_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic [NSEG-1:1]   spec_c;
  logic [NSEG-1:0]   co;
  logic [WIDTH-1:0]  seg_sum;
  logic [NSEG-1:1]   mis;
  logic              accept;

  // Window carry: x + y overflows P bits exactly when x > ~y.
  always_comb begin
    spec_c = '0;
    for (int j = 1; j < NSEG; j++) begin
      spec_c[j] = a[j*SEG-1 -: P] > ~b[j*SEG-1 -: P];
    end
  end

  always_comb begin
    co      = '0;
    seg_sum = '0;
    for (int j = 0; j < NSEG; j++) begin
      {co[j], seg_sum[j*SEG +: SEG]} = {1'b0, a_q[j*SEG +: SEG]}
                                     + {1'b0, b_q[j*SEG +: SEG]}
                                     + {{SEG{1'b0}}, c_q[j]};
    end
  end

  always_comb begin
    mis = '0;
    for (int j = 1; j < NSEG; j++) begin
      mis[j] = c_q[j] ^ co[j-1];
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;
  assign ncorr     = ncorr_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    c_d     = c_q;
    err_d   = err_q;
    ncorr_d = ncorr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      CALC: begin
        // ncorr is still zero only on the first evaluation of a transaction.
        if (ncorr_q == '0) begin
          err_d = |mis;
        end
        if (!mode_q || (mis == '0)) begin
          sum_d   = seg_sum;
          cout_d  = co[NSEG-1];
          state_d = DONE;
        end else begin
          c_d[NSEG-1:1] = co[NSEG-2:0];
          ncorr_d       = ncorr_q + NW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      a_d     = a;
      b_d     = b;
      mode_d  = mode;
      c_d     = {spec_c, cin};
      err_d   = 1'b0;
      ncorr_d = '0;
      state_d = CALC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      c_q     <= '0;
      err_q   <= 1'b0;
      ncorr_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      err_q   <= err_d;
      ncorr_q <= ncorr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule
